// File: rtl/proc.sv
// Shared processor-wide widths and the write-back source identifiers.
package proc;

   localparam int ARCH_BITS    = 32;
   localparam int REG_IDX_BITS = 5;
   localparam int NUM_SRC      = 3;

   typedef enum logic [1:0] {
      SRC_ALU    = 2'd0,
      SRC_DCACHE = 2'd1,
      SRC_MUL    = 2'd2
   } src_e;

   // Round-robin successor over the three sources.
   function automatic logic [1:0] next_src(input logic [1:0] src);
      case (src)
         2'd0:    next_src = 2'd1;
         2'd1:    next_src = 2'd2;
         default: next_src = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result buffer: DEPTH entries, wrap-around pointers, no pass-through.
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // ready looks only at the stored count, so a same-cycle pop never opens a slot.
   assign ready   = rst && (count < CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && ready && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: three buffered result sources, round-robin grant,
// registered single-port register-file write.
module wb_arbiter
   import proc::*;
#(
   parameter int ARCH_BITS    = proc::ARCH_BITS,
   parameter int REG_IDX_BITS = proc::REG_IDX_BITS,
   parameter int DEPTH        = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    valid0,
   input  logic                    valid1,
   input  logic                    valid2,
   input  logic [ARCH_BITS-1:0]    data0,
   input  logic [ARCH_BITS-1:0]    data1,
   input  logic [ARCH_BITS-1:0]    data2,
   input  logic [REG_IDX_BITS-1:0] dst0,
   input  logic [REG_IDX_BITS-1:0] dst1,
   input  logic [REG_IDX_BITS-1:0] dst2,
   input  logic                    we0,
   input  logic                    we1,
   input  logic                    we2,
   output logic                    ready0,
   output logic                    ready1,
   output logic                    ready2,
   output logic                    wbValid,
   output logic [ARCH_BITS-1:0]    wbData,
   output logic [REG_IDX_BITS-1:0] wbDst,
   output logic [1:0]              wbSrc
);

   localparam int EW = ARCH_BITS + REG_IDX_BITS;

   logic [NUM_SRC-1:0] push_v;
   logic [NUM_SRC-1:0] pop_v;
   logic [NUM_SRC-1:0] ready_v;
   logic [NUM_SRC-1:0] empty_v;
   logic [EW-1:0]      din_v  [NUM_SRC];
   logic [EW-1:0]      head_v [NUM_SRC];

   logic [1:0] last_grant;
   logic [1:0] grant_idx;
   logic [1:0] cand;
   logic       grant_valid;
   logic       grant_eff;

   // Results with we=0 are handshaked away without occupying a slot.
   assign push_v   = {valid2 && we2, valid1 && we1, valid0 && we0};
   assign din_v[0] = {dst0, data0};
   assign din_v[1] = {dst1, data1};
   assign din_v[2] = {dst2, data2};
   assign ready0   = ready_v[0];
   assign ready1   = ready_v[1];
   assign ready2   = ready_v[2];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
      wb_fifo #(
         .WIDTH (EW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (push_v[i]),
         .pop   (pop_v[i]),
         .din   (din_v[i]),
         .ready (ready_v[i]),
         .empty (empty_v[i]),
         .head  (head_v[i])
      );
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = last_grant;
      cand        = last_grant;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = next_src(cand);
         if (!grant_valid && !empty_v[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // A flush cycle neither pops nor advances the round-robin pointer.
   assign grant_eff = grant_valid && !flush;

   always_comb begin
      pop_v = '0;
      if (grant_eff) pop_v[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant <= SRC_MUL;
         wbValid    <= 1'b0;
         wbData     <= '0;
         wbDst      <= '0;
         wbSrc      <= '0;
      end else begin
         wbValid <= grant_eff;
         if (grant_eff) begin
            last_grant <= grant_idx;
            wbData     <= head_v[grant_idx][ARCH_BITS-1:0];
            wbDst      <= head_v[grant_idx][EW-1:ARCH_BITS];
            wbSrc      <= grant_idx;
         end
      end
   end

endmodule
